// File: rtl/axi_sub_mem_pkg.sv
// Shared types for the AXI4-Lite subordinate memory: response codes and the
// write/read channel state encodings.
package axi_helper;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_A,
    WR_HAVE_D,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

endpackage

// File: rtl/axi_sub_mem_array.sv
// Word-addressed storage with one byte-enabled write port and one registered
// read port; contents survive reset.
module sub_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read and write share one edge; the read sees the pre-edge contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_sub_mem.sv
// AXI4-Lite subordinate terminating AW/W/B/AR/R into an internal memory.
// One outstanding write and one outstanding read, handled by independent FSMs.
module axi_sub_mem
  import axi_helper::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MEM_DEPTH) << 2;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < ADDR_LIMIT;
  endfunction

  // ---------------- write channel ----------------
  wr_state_t           wr_state_reg, wr_state_next;
  logic [ADDR_W-1:0]   aw_addr_reg, aw_addr_next;
  logic [DATA_W-1:0]   w_data_reg, w_data_next;
  logic [STRB_W-1:0]   w_strb_reg, w_strb_next;
  resp_t               bresp_reg, bresp_next;

  logic                aw_hs, w_hs, commit, cm_in_range;
  logic [ADDR_W-1:0]   cm_addr;
  logic [DATA_W-1:0]   cm_data;
  logic [STRB_W-1:0]   cm_strb;
  logic                mem_we;

  assign AWREADY = (wr_state_reg == WR_IDLE) || (wr_state_reg == WR_HAVE_D);
  assign WREADY  = (wr_state_reg == WR_IDLE) || (wr_state_reg == WR_HAVE_A);
  assign BVALID  = (wr_state_reg == WR_RESP);
  assign BRESP   = bresp_reg;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;

  always_comb begin
    wr_state_next = wr_state_reg;
    aw_addr_next  = aw_addr_reg;
    w_data_next   = w_data_reg;
    w_strb_next   = w_strb_reg;
    bresp_next    = bresp_reg;
    commit        = 1'b0;
    cm_addr       = aw_addr_reg;
    cm_data       = w_data_reg;
    cm_strb       = w_strb_reg;

    case (wr_state_reg)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          commit  = 1'b1;
          cm_addr = AWADDR;
          cm_data = WDATA;
          cm_strb = WSTRB;
        end else if (aw_hs) begin
          aw_addr_next  = AWADDR;
          wr_state_next = WR_HAVE_A;
        end else if (w_hs) begin
          w_data_next   = WDATA;
          w_strb_next   = WSTRB;
          wr_state_next = WR_HAVE_D;
        end
      end
      WR_HAVE_A: begin
        if (w_hs) begin
          commit  = 1'b1;
          cm_data = WDATA;
          cm_strb = WSTRB;
        end
      end
      WR_HAVE_D: begin
        if (aw_hs) begin
          commit  = 1'b1;
          cm_addr = AWADDR;
        end
      end
      WR_RESP: begin
        if (BREADY) wr_state_next = WR_IDLE;
      end
      default: wr_state_next = WR_IDLE;
    endcase

    cm_in_range = addr_in_range(cm_addr);
    if (commit) begin
      wr_state_next = WR_RESP;
      bresp_next    = cm_in_range ? OKAY : DECERR;
    end
  end

  // Out-of-range commits still respond, but never touch the array.
  assign mem_we = commit && cm_in_range;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_state_reg <= WR_IDLE;
      aw_addr_reg  <= '0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
      bresp_reg    <= OKAY;
    end else begin
      wr_state_reg <= wr_state_next;
      aw_addr_reg  <= aw_addr_next;
      w_data_reg   <= w_data_next;
      w_strb_reg   <= w_strb_next;
      bresp_reg    <= bresp_next;
    end
  end

  // ---------------- read channel ----------------
  rd_state_t           rd_state_reg, rd_state_next;
  resp_t               rresp_reg, rresp_next;
  logic                rd_zero_reg, rd_zero_next;
  logic                ar_hs, ar_in_range, mem_re;
  logic [DATA_W-1:0]   mem_rdata;

  assign ARREADY     = (rd_state_reg == RD_IDLE);
  assign RVALID      = (rd_state_reg == RD_RESP);
  assign RRESP       = rresp_reg;
  assign ar_hs       = ARVALID && ARREADY;
  assign ar_in_range = addr_in_range(ARADDR);

  always_comb begin
    rd_state_next = rd_state_reg;
    rresp_next    = rresp_reg;
    rd_zero_next  = rd_zero_reg;
    mem_re        = 1'b0;

    case (rd_state_reg)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_state_next = RD_RESP;
          rresp_next    = ar_in_range ? OKAY : DECERR;
          rd_zero_next  = !ar_in_range;
          mem_re        = ar_in_range;
        end
      end
      RD_RESP: begin
        if (RREADY) rd_state_next = RD_IDLE;
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state_reg <= RD_IDLE;
      rresp_reg    <= OKAY;
      rd_zero_reg  <= 1'b1;
    end else begin
      rd_state_reg <= rd_state_next;
      rresp_reg    <= rresp_next;
      rd_zero_reg  <= rd_zero_next;
    end
  end

  // The array output register has no reset, so RDATA is forced to zero
  // after reset and for out-of-range reads; otherwise it holds until the next AR.
  assign RDATA = rd_zero_reg ? '0 : mem_rdata;

  sub_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH),
    .IDX_W  (IDX_W),
    .STRB_W (STRB_W)
  ) u_mem (
    .clk   (ACLK),
    .we    (mem_we),
    .waddr (cm_addr[IDX_W+1:2]),
    .wstrb (cm_strb),
    .wdata (cm_data),
    .re    (mem_re),
    .raddr (ARADDR[IDX_W+1:2]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_axi_sub_mem.sv
// Scoreboard bench for axi_sub_mem: randomized AXI4-Lite traffic checked
// against a word-array reference model, plus directed corner cases.
module tb_axi_sub_mem;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic [AW-1:0] AWADDR;
  logic          AWVALID;
  logic          AWREADY;
  logic [DW-1:0] WDATA;
  logic [3:0]    WSTRB;
  logic          WVALID;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY;
  logic [AW-1:0] ARADDR;
  logic          ARVALID;
  logic          ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY;

  always #5 ACLK = ~ACLK;

  axi_sub_mem #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain word array, responses from the address rules.
  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } r_exp_t;

  logic [31:0] model_mem [DEPTH];
  logic [1:0]  b_exp_q [$];
  r_exp_t      r_exp_q [$];
  int          b_issued = 0, b_done = 0, r_issued = 0, r_done = 0;
  bit          bp = 1'b0;
  logic [1:0]  b_e;
  r_exp_t      r_e;

  // Monitor: a handshake is certain at the next edge when VALID&READY mid-cycle.
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (BVALID && BREADY) begin
        if (b_exp_q.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
        else begin
          b_e = b_exp_q.pop_front();
          $display("B  resp=%0d (exp %0d)", BRESP, b_e);
          chk("bresp", 64'(BRESP), 64'(b_e));
        end
        b_done++;
      end
      if (RVALID && RREADY) begin
        if (r_exp_q.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
        else begin
          r_e = r_exp_q.pop_front();
          $display("R  resp=%0d data=%08h (exp %0d %08h)", RRESP, RDATA, r_e.resp, r_e.data);
          chk("rresp", 64'(RRESP), 64'(r_e.resp));
          chk("rdata", 64'(RDATA), 64'(r_e.data));
        end
        r_done++;
      end
    end
  end

  // Response-channel ready generator; bp forces backpressure.
  initial begin
    BREADY = 1'b0;
    RREADY = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      BREADY = !bp && ($urandom_range(0, 3) != 0);
      RREADY = !bp && ($urandom_range(0, 3) != 0);
    end
  end

  // All drivers start and return at 1 time unit after a rising edge.
  task automatic send_aw(input logic [31:0] addr, input int dly);
    int c = 0;
    repeat (dly) @(posedge ACLK);
    if (dly > 0) #1;
    AWADDR = addr; AWVALID = 1'b1;
    @(negedge ACLK);
    while (!AWREADY && c < 100) begin @(negedge ACLK); c++; end
    if (c >= 100) chk("aw_timeout", 64'd0, 64'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; AWADDR = $urandom;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    int c = 0;
    repeat (dly) @(posedge ACLK);
    if (dly > 0) #1;
    WDATA = data; WSTRB = strb; WVALID = 1'b1;
    @(negedge ACLK);
    while (!WREADY && c < 100) begin @(negedge ACLK); c++; end
    if (c >= 100) chk("w_timeout", 64'd0, 64'd1);
    @(posedge ACLK); #1;
    WVALID = 1'b0; WDATA = $urandom;
  endtask

  task automatic send_ar(input logic [31:0] addr, input int dly);
    int c = 0;
    repeat (dly) @(posedge ACLK);
    if (dly > 0) #1;
    ARADDR = addr; ARVALID = 1'b1;
    @(negedge ACLK);
    while (!ARREADY && c < 100) begin @(negedge ACLK); c++; end
    if (c >= 100) chk("ar_timeout", 64'd0, 64'd1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0; ARADDR = $urandom;
    chk("r_latency", 64'(RVALID), 64'd1);
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx = int'(addr[11:2]);
    if (addr < 32'h1000) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
      b_exp_q.push_back(2'b00);
    end else begin
      b_exp_q.push_back(2'b11);
    end
    b_issued++;
  endtask

  task automatic expect_read(input logic [31:0] addr);
    r_exp_t e;
    if (addr < 32'h1000) begin e.resp = 2'b00; e.data = model_mem[int'(addr[11:2])]; end
    else begin e.resp = 2'b11; e.data = 32'h0; end
    r_exp_q.push_back(e);
    r_issued++;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awd, input int wd);
    expect_write(addr, data, strb);
    fork
      send_aw(addr, awd);
      send_w(data, strb, wd);
    join
    chk("b_latency", 64'(BVALID), 64'd1);
    chk("awready_busy", 64'(AWREADY), 64'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int dly);
    expect_read(addr);
    send_ar(addr, dly);
  endtask

  task automatic wait_b();
    int c = 0;
    do begin @(posedge ACLK); c++; end while (b_done < b_issued && c < 200);
    #1;
    if (b_done < b_issued) chk("b_timeout", 64'(b_done), 64'(b_issued));
  endtask

  task automatic wait_r();
    int c = 0;
    do begin @(posedge ACLK); c++; end while (r_done < r_issued && c < 200);
    #1;
    if (r_done < r_issued) chk("r_timeout", 64'(r_done), 64'(r_issued));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, 64'(AWREADY), 64'd1);
    chk({tag, "_wready"},  64'(WREADY),  64'd1);
    chk({tag, "_arready"}, 64'(ARREADY), 64'd1);
    chk({tag, "_bvalid"},  64'(BVALID),  64'd0);
    chk({tag, "_rvalid"},  64'(RVALID),  64'd0);
    chk({tag, "_bresp"},   64'(BRESP),   64'd0);
    chk({tag, "_rresp"},   64'(RRESP),   64'd0);
    chk({tag, "_rdata"},   64'(RDATA),   64'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 32'h1000 + $urandom_range(0, 32'h7fff_0000);
    return {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    ARADDR = '0; ARVALID = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    chk_reset_outputs("rst0");
    ARESETn = 1'b1;
    @(posedge ACLK); #1;

    // Basic aligned write then read-back
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
    wait_b();
    do_read(32'h10, 0);
    wait_r();

    // Fill the working window so every later read has defined contents
    for (int i = 0; i < 16; i++) begin
      do_write(32'(i * 4), $urandom, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2));
      wait_b();
    end

    // W arrives three cycles before AW
    expect_write(32'h20, 32'h1122_3344, 4'hF);
    send_w(32'h1122_3344, 4'hF, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      chk("wready_wait", 64'(WREADY), 64'd0);
      @(posedge ACLK); #1;
    end
    send_aw(32'h20, 0);
    chk("b_latency_wfirst", 64'(BVALID), 64'd1);
    wait_b();
    do_read(32'h20, 0);
    wait_r();

    // Partial strobe over an all-ones word
    do_write(32'h30, 32'hFFFF_FFFF, 4'hF, 0, 0);
    wait_b();
    do_write(32'h30, 32'h0000_0000, 4'h5, 1, 0);
    wait_b();
    do_read(32'h30, 0);
    wait_r();

    // Out of range write and read
    do_write(32'h1000, 32'hA5A5_A5A5, 4'hF, 0, 0);
    wait_b();
    do_read(32'h1000, 0);
    wait_r();
    do_read(32'h0, 0);
    wait_r();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3));
        wait_b();
      end else begin
        do_read(rand_addr(), $urandom_range(0, 2));
        wait_r();
      end
    end

    // Same-edge write commit and read of the same word: read sees old data
    expect_read(32'h18);
    expect_write(32'h18, 32'hCAFE_F00D, 4'hF);
    fork
      send_aw(32'h18, 0);
      send_w(32'hCAFE_F00D, 4'hF, 0);
      send_ar(32'h18, 0);
    join
    wait_b();
    wait_r();
    do_read(32'h18, 0);
    wait_r();

    // Backpressure on both response channels for five cycles
    bp = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    fork
      do_write(32'h8, 32'h5555_AAAA, 4'hF, 0, 0);
      do_read(32'h24, 0);
    join
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      chk("bp_bvalid",  64'(BVALID),  64'd1);
      chk("bp_bresp",   64'(BRESP),   64'd0);
      chk("bp_awready", 64'(AWREADY), 64'd0);
      chk("bp_wready",  64'(WREADY),  64'd0);
      chk("bp_rvalid",  64'(RVALID),  64'd1);
      chk("bp_rdata",   64'(RDATA),   64'(model_mem[9]));
      chk("bp_arready", 64'(ARREADY), 64'd0);
    end
    @(posedge ACLK); #1;
    bp = 1'b0;
    wait_b();
    wait_r();

    // Asynchronous reset with a write half-captured and a read response pending
    bp = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    do_read(32'h10, 0);
    send_aw(32'h14, 0);
    chk("pre_rst_rvalid", 64'(RVALID), 64'd1);
    #2;
    ARESETn = 1'b0;
    #1;
    chk_reset_outputs("rst1");
    r_exp_q.delete();
    r_issued = r_done;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    bp = 1'b0;
    @(posedge ACLK); #1;
    do_read(32'h10, 0);
    wait_r();
    do_read(32'h14, 0);
    wait_r();
    do_write(32'h14, 32'h0BAD_F00D, 4'hF, 0, 2);
    wait_b();
    do_read(32'h14, 0);
    wait_r();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
